// File: rtl/soc_system_pll_lock_mgr.sv
// Lock manager for the HD pixel PLL, clocked by the PLL's reference clock.
// It drives the PLL reset and synchronises and debounces the PLL locked flag.
// It retries on lock timeout and releases the pixel-domain reset once lock is stable.
// Optional feature: define PLL_LOCK_STATS_EN to build the lock-loss counter.
//
// Ports:
//   refclk        in   reference clock, the only clock
//   rst           in   asynchronous active-high reset
//   pll_locked    in   raw PLL locked flag, asynchronous to refclk
//   relock_req    in   single-cycle pulse that restarts the whole sequence
//   pll_rst       out  PLL reset, active-high
//   pix_rst       out  pixel-domain reset request, active-high
//   ready         out  1 while running with a stable lock
//   fail          out  1 after too many failed lock attempts
//   retry_cnt     out  failed attempts since the last run or relock request
//   lock_loss_cnt out  lock losses seen while running (0 unless the stats build is used)
module soc_system_pll_lock_mgr #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 4
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        relock_req,
    output logic        pll_rst,
    output logic        pix_rst,
    output logic        ready,
    output logic        fail,
    output logic [3:0]  retry_cnt,
    output logic [15:0] lock_loss_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                             PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                             MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    retry_n;
    logic [3:0]    retry_inc;
    logic          sync1;
    logic          lk;

    // Two-flop synchroniser for the raw locked flag.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        retry_n   = retry_cnt;
        retry_inc = retry_cnt + 4'd1;
        if (relock_req) begin
            state_n = S_PLL_RST;
            retry_n = 4'd0;
        end else begin
            unique case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_n = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still counts as a lock.
                    if (lk) begin
                        state_n = S_STABLE;
                    end else if (cnt == TO_LAST) begin
                        retry_n = retry_inc;
                        state_n = (retry_inc == RETRY_MAX) ? S_FAIL : S_PLL_RST;
                    end
                end
                S_STABLE: begin
                    if (!lk) begin
                        state_n = S_WAIT_LOCK;
                    end else if (cnt == STAB_LAST) begin
                        state_n = S_RUN;
                        retry_n = 4'd0;
                    end
                end
                S_RUN: begin
                    cnt_n = cnt;
                    if (!lk) begin
                        state_n = S_PLL_RST;
                    end
                end
                S_FAIL: begin
                    cnt_n = cnt;
                end
                default: begin
                    state_n = S_PLL_RST;
                end
            endcase
        end
        // Every state change, and any relock, restarts the shared counter.
        if (relock_req || (state_n != state)) begin
            cnt_n = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the
    // same edge as the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            pll_rst   <= 1'b1;
            pix_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            pll_rst   <= (state_n == S_PLL_RST);
            pix_rst   <= (state_n != S_RUN);
            ready     <= (state_n == S_RUN);
            fail      <= (state_n == S_FAIL);
        end
    end

`ifdef PLL_LOCK_STATS_EN
    logic lost;

    // A relock request in the same cycle takes precedence and is not a loss.
    assign lost = (state == S_RUN) && !lk && !relock_req;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= 16'h0000;
        end else if (lost && (lock_loss_cnt != 16'hFFFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end
    end
`else
    assign lock_loss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_soc_system_pll_lock_mgr.sv
// Self-checking bench for soc_system_pll_lock_mgr with small sim parameters.
// A cycle model is checked every cycle, and hand-timed directed checks pin the model.
module tb_soc_system_pll_lock_mgr;

    localparam int PR = 4;
    localparam int LS = 8;
    localparam int TO = 20;
    localparam int MR = 2;

`ifdef PLL_LOCK_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif
    localparam int LL1 = STATS;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        relock_req = 1'b0;
    logic        pll_rst;
    logic        pix_rst;
    logic        ready;
    logic        fail;
    logic [3:0]  retry_cnt;
    logic [15:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 refclk = ~refclk;

    soc_system_pll_lock_mgr #(
        .PLL_RST_CYCLES(PR),
        .LOCK_STABLE_CYCLES(LS),
        .LOCK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MR)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst(pll_rst),
        .pix_rst(pix_rst),
        .ready(ready),
        .fail(fail),
        .retry_cnt(retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    // Model: mode plus the number of cycles already spent in it.
    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STAB = 2;
    localparam int M_RUN  = 3;
    localparam int M_FAIL = 4;

    int m_mode = M_RST;
    int m_t = 0;
    int m_retry = 0;
    int m_loss = 0;
    bit m_h0 = 1'b0;
    bit m_h1 = 1'b0;
    bit m_lk = 1'b0;

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_mode = M_RST;
            m_t = 0;
            m_retry = 0;
            m_loss = 0;
            m_h0 = 1'b0;
            m_h1 = 1'b0;
        end else begin
            m_lk = m_h1;
            m_h1 = m_h0;
            m_h0 = pll_locked;
            m_t = m_t + 1;
            if (relock_req) begin
                m_mode = M_RST;
                m_t = 0;
                m_retry = 0;
            end else if (m_mode == M_RST) begin
                if (m_t == PR) begin
                    m_mode = M_WAIT;
                    m_t = 0;
                end
            end else if (m_mode == M_WAIT) begin
                if (m_lk) begin
                    m_mode = M_STAB;
                    m_t = 0;
                end else if (m_t == TO) begin
                    m_retry = m_retry + 1;
                    m_mode = (m_retry == MR) ? M_FAIL : M_RST;
                    m_t = 0;
                end
            end else if (m_mode == M_STAB) begin
                if (!m_lk) begin
                    m_mode = M_WAIT;
                    m_t = 0;
                end else if (m_t == LS) begin
                    m_mode = M_RUN;
                    m_t = 0;
                    m_retry = 0;
                end
            end else if (m_mode == M_RUN) begin
                if (!m_lk) begin
                    if (m_loss < 65535) m_loss = m_loss + 1;
                    m_mode = M_RST;
                    m_t = 0;
                end
            end
        end
    end

    logic        e_pll_rst;
    logic        e_pix_rst;
    logic        e_ready;
    logic        e_fail;
    logic [3:0]  e_retry;
    logic [15:0] e_loss;

    always @(negedge refclk) begin
        e_pll_rst = (m_mode == M_RST);
        e_pix_rst = (m_mode != M_RUN);
        e_ready   = (m_mode == M_RUN);
        e_fail    = (m_mode == M_FAIL);
        e_retry   = 4'(m_retry);
        e_loss    = (STATS != 0) ? 16'(m_loss) : 16'h0000;
        n_tests++;
        if ({pll_rst, pix_rst, ready, fail, retry_cnt, lock_loss_cnt} !==
            {e_pll_rst, e_pix_rst, e_ready, e_fail, e_retry, e_loss}) begin
            n_fail++;
            $display("FAIL model t=%0t got pll_rst=%b pix_rst=%b ready=%b fail=%b retry=%0d loss=%0d want %b %b %b %b %0d %0d",
                     $time, pll_rst, pix_rst, ready, fail, retry_cnt, lock_loss_cnt,
                     e_pll_rst, e_pix_rst, e_ready, e_fail, e_retry, e_loss);
        end
    end

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, got, want);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge refclk);
            cyc++;
        end
    endtask

    initial begin
        repeat (3) @(negedge refclk);
        check("rst_pll_rst", 16'(pll_rst), 16'd1);
        check("rst_pix_rst", 16'(pix_rst), 16'd1);
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_fail", 16'(fail), 16'd0);
        check("rst_retry", 16'(retry_cnt), 16'd0);
        rst = 1'b0;
        cyc = 0;

        // Lock arrives at cycle 10
        goto(3);
        check("t1_pll_rst_hi", 16'(pll_rst), 16'd1);
        goto(4);
        check("t1_pll_rst_lo", 16'(pll_rst), 16'd0);
        goto(10);
        pll_locked = 1'b1;
        goto(20);
        check("t1_ready_early", 16'(ready), 16'd0);
        goto(21);
        check("t1_ready", 16'(ready), 16'd1);
        check("t1_pix_rst", 16'(pix_rst), 16'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        goto(23);
        check("t4_ready_hold", 16'(ready), 16'd1);
        goto(24);
        check("t4_ready", 16'(ready), 16'd0);
        check("t4_pix_rst", 16'(pix_rst), 16'd1);
        check("t4_pll_rst", 16'(pll_rst), 16'd1);
        check("t4_loss", lock_loss_cnt, 16'(LL1));
        pll_locked = 1'b1;

        // One-cycle glitch while stable
        goto(32);
        pll_locked = 1'b0;
        goto(33);
        pll_locked = 1'b1;
        goto(43);
        check("t3_ready_early", 16'(ready), 16'd0);
        goto(44);
        check("t3_ready", 16'(ready), 16'd1);
        check("t3_retry", 16'(retry_cnt), 16'd0);

        // Relock coincident with lock falling
        pll_locked = 1'b0;
        goto(46);
        check("t5_ready_hold", 16'(ready), 16'd1);
        relock_req = 1'b1;
        goto(47);
        relock_req = 1'b0;
        check("t5_ready", 16'(ready), 16'd0);
        check("t5_pix_rst", 16'(pix_rst), 16'd1);
        check("t5_pll_rst", 16'(pll_rst), 16'd1);
        check("t5_loss", lock_loss_cnt, 16'(LL1));
        pll_locked = 1'b1;

        // Asynchronous reset mid-STABLE
        goto(55);
        check("t6_stable_pll", 16'(pll_rst), 16'd0);
        check("t6_stable_rdy", 16'(ready), 16'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_pll_rst", 16'(pll_rst), 16'd1);
        check("t6_pix_rst", 16'(pix_rst), 16'd1);
        check("t6_ready", 16'(ready), 16'd0);
        check("t6_fail", 16'(fail), 16'd0);
        check("t6_retry", 16'(retry_cnt), 16'd0);
        check("t6_loss", lock_loss_cnt, 16'd0);
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
        goto(3);
        check("t6_pll_rst_hi", 16'(pll_rst), 16'd1);
        goto(4);
        check("t6_pll_rst_lo", 16'(pll_rst), 16'd0);
        goto(12);
        check("t6_ready_early", 16'(ready), 16'd0);
        goto(13);
        check("t6_ready", 16'(ready), 16'd1);

        // Lock never returns: timeouts, then FAIL
        pll_locked = 1'b0;
        goto(16);
        check("t2_leave_run", 16'(ready), 16'd0);
        check("t2_loss", lock_loss_cnt, 16'(LL1));
        goto(39);
        check("t2_retry0", 16'(retry_cnt), 16'd0);
        goto(40);
        check("t2_retry1", 16'(retry_cnt), 16'd1);
        check("t2_pll_rst1", 16'(pll_rst), 16'd1);
        goto(63);
        check("t2_fail_early", 16'(fail), 16'd0);
        goto(64);
        check("t2_fail", 16'(fail), 16'd1);
        check("t2_retry2", 16'(retry_cnt), 16'd2);
        check("t2_pix_rst", 16'(pix_rst), 16'd1);
        check("t2_pll_rst", 16'(pll_rst), 16'd0);
        goto(66);
        check("t2_fail_hold", 16'(fail), 16'd1);
        relock_req = 1'b1;
        goto(67);
        relock_req = 1'b0;
        check("t2_relock_fail", 16'(fail), 16'd0);
        check("t2_relock_retry", 16'(retry_cnt), 16'd0);
        check("t2_relock_pll", 16'(pll_rst), 16'd1);

        // Lock rises on the timeout cycle: lock wins
        goto(88);
        pll_locked = 1'b1;
        goto(91);
        check("tb_race_retry", 16'(retry_cnt), 16'd0);
        check("tb_race_fail", 16'(fail), 16'd0);
        check("tb_race_pll", 16'(pll_rst), 16'd0);
        goto(98);
        check("tb_race_rdy_early", 16'(ready), 16'd0);
        goto(99);
        check("tb_race_ready", 16'(ready), 16'd1);
        goto(103);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
